// File: rtl/ram_pkg.sv
// Shared types and limits for the latency-programmable main-memory model.
package ram_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int MAX_LAT = 15;

endpackage

// File: rtl/ram_array.sv
// Word storage: asynchronous read port, synchronous write port, contents survive reset.
module ram_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_latency_ctrl.sv
// Main-memory model with LAT wait cycles per access, sitting behind memory_control.
// The request is latched on entry; any change of op/word/data restarts the wait.
module ram_latency_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              Ren,
  input  logic              Wen,
  input  logic [31:0]       ramaddr,
  input  logic [DATA_W-1:0] ramstore,
  output logic [DATA_W-1:0] ramload,
  output logic              busy_o
);

  // Handshake: a request (Ren|Wen) is held by the requester until a cycle in
  // which busy_o=0; that cycle is the completion cycle (ramload valid for reads,
  // write committed at its closing edge). Dropping or changing the request
  // before then abandons the access without side effects.

  localparam logic [3:0] LAT_C = 4'(LAT);

  if (LAT < 0 || LAT > MAX_LAT) begin : g_lat_range
    $error("ram_latency_ctrl: LAT out of range 0..15");
  end

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  op_t               lat_op;
  logic [ADDR_W-1:0] lat_word;
  logic [DATA_W-1:0] lat_data;
  logic              load_req;

  logic              req;
  op_t               req_op;
  logic [ADDR_W-1:0] req_word;
  logic              match;

  logic              complete;
  op_t               cpl_op;
  logic [ADDR_W-1:0] cpl_word;
  logic [DATA_W-1:0] cpl_data;
  logic              mem_we;
  logic [DATA_W-1:0] rd_data;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{ramaddr[31:ADDR_W+2], ramaddr[1:0]};

  // Ren&Wen resolves to a write.
  assign req      = Ren | Wen;
  assign req_op   = Wen ? OP_WR : OP_RD;
  assign req_word = ramaddr[ADDR_W+1:2];
  assign match    = (req_op == lat_op) && (req_word == lat_word) && (ramstore == lat_data);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_op   <= OP_RD;
      lat_word <= '0;
      lat_data <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load_req) begin
        lat_op   <= req_op;
        lat_word <= req_word;
        lat_data <= ramstore;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    load_req = 1'b0;
    busy_o   = 1'b0;
    complete = 1'b0;
    cpl_op   = req_op;
    cpl_word = req_word;
    cpl_data = ramstore;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (LAT_C == 4'd0) begin
            complete = 1'b1;
          end else begin
            busy_o   = 1'b1;
            load_req = 1'b1;
            state_n  = ACCESS;
            cnt_n    = 4'd1;
          end
        end
      end
      ACCESS: begin
        cpl_op   = lat_op;
        cpl_word = lat_word;
        cpl_data = lat_data;
        if (!req) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!match) begin
          busy_o   = 1'b1;
          load_req = 1'b1;
          cnt_n    = 4'd1;
        end else if (cnt != LAT_C) begin
          busy_o = 1'b1;
          cnt_n  = cnt + 4'd1;
        end else begin
          complete = 1'b1;
          state_n  = IDLE;
          cnt_n    = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    // Outputs and writes are suppressed while reset is asserted, even with a request present.
    if (!nRST) begin
      busy_o   = 1'b0;
      complete = 1'b0;
      load_req = 1'b0;
    end
  end

  assign mem_we  = complete && (cpl_op == OP_WR);
  assign ramload = (complete && (cpl_op == OP_RD)) ? rd_data : '0;

  ram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (CLK),
    .we   (mem_we),
    .waddr(cpl_word),
    .wdata(cpl_data),
    .raddr(cpl_word),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_ram_latency_ctrl.sv
// Bench for ram_latency_ctrl: LAT=2 and LAT=0 instances share one request stream,
// checked against directed constants and a request-age reference model.
module tb_ram_latency_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        Ren = 1'b0;
  logic        Wen = 1'b0;
  logic [31:0] ramaddr = '0;
  logic [31:0] ramstore = '0;
  logic [31:0] ramload, ramload0;
  logic        busy_o, busy0;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state, index 0 = LAT 2 instance, 1 = LAT 0 instance
  int          lat_m [2] = '{2, 0};
  logic [31:0] mem_m [2][1024];
  logic        pv [2];
  logic [42:0] pk [2];
  int          age [2];
  int          new_age [2];
  logic        exp_busy [2];
  logic        exp_cpl [2];
  logic [31:0] exp_load [2];
  logic        cur_req, cur_wr, cur_rst;
  logic [42:0] cur_key;
  logic [9:0]  cur_wd;
  logic [31:0] cur_d;
  logic        pending = 1'b0;
  logic [31:0] exp_q [$];

  always #5 CLK = ~CLK;

  ram_latency_ctrl #(.DATA_W(32), .ADDR_W(10), .LAT(2)) dut (
    .CLK(CLK), .nRST(nRST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .busy_o(busy_o)
  );

  ram_latency_ctrl #(.DATA_W(32), .ADDR_W(10), .LAT(0)) dut0 (
    .CLK(CLK), .nRST(nRST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload0), .busy_o(busy0)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // A request's age is the number of consecutive cycles it has been presented
  // unchanged since it was first seen; it completes when age reaches the latency.
  task automatic model_eval();
    logic        req;
    logic [9:0]  wd;
    logic [42:0] key;
    int          a;
    req = Ren | Wen;
    wd  = ramaddr[11:2];
    key = {Wen, wd, ramstore};
    for (int i = 0; i < 2; i++) begin
      exp_busy[i] = 1'b0;
      exp_cpl[i]  = 1'b0;
      exp_load[i] = '0;
      new_age[i]  = 0;
      if (nRST && req) begin
        a = (pv[i] && key == pk[i]) ? age[i] + 1 : 0;
        new_age[i]  = a;
        exp_busy[i] = (a < lat_m[i]);
        exp_cpl[i]  = (a == lat_m[i]);
        if (exp_cpl[i] && !Wen) exp_load[i] = mem_m[i][wd];
      end
    end
    cur_req = req; cur_key = key; cur_wd = wd; cur_wr = Wen; cur_d = ramstore; cur_rst = nRST;
  endtask

  task automatic model_commit();
    for (int i = 0; i < 2; i++) begin
      if (!cur_rst) begin
        pv[i] = 1'b0;
      end else begin
        if (exp_cpl[i] && cur_wr) mem_m[i][cur_wd] = cur_d;
        pv[i]  = cur_req && !exp_cpl[i];
        pk[i]  = cur_key;
        age[i] = new_age[i];
      end
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, sample at the falling edge.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge CLK);
    if (pending) model_commit();
    #1;
    Ren = r; Wen = w; ramaddr = a; ramstore = d;
    @(negedge CLK);
    model_eval();
    pending = 1'b1;
  endtask

  task automatic assert_reset();
    @(posedge CLK);
    if (pending) model_commit();
    pending = 1'b0;
    #1;
    nRST = 1'b0; Ren = 1'b0; Wen = 1'b0;
    for (int i = 0; i < 2; i++) pv[i] = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge CLK);
    if (pending) model_commit();
    pending = 1'b0;
    #1;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) pv[i] = 1'b0;
    Ren = 1'b1; Wen = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_cmp++; if (ramload !== 32'h0) begin n_fail++; $display("FAIL reset_load: got %h want 0", ramload); end
      n_cmp++; if (busy0 !== 1'b0 || ramload0 !== 32'h0) begin n_fail++; $display("FAIL reset_lat0: got %b/%h want 0/0", busy0, ramload0); end
    end
    Ren = 1'b0; Wen = 1'b0;
    release_reset();
    repeat (2) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      n_cmp++; if (busy_o !== 1'b0 || ramload !== 32'h0) begin n_fail++; $display("FAIL idle_after_reset: got %b/%h want 0/0", busy_o, ramload); end
    end
  endtask

  task automatic test_fill();
    logic [31:0] dv;
    for (int wd = 0; wd < 1024; wd++) begin
      dv = $urandom;
      repeat (3) step(1'b0, 1'b1, 32'(wd) << 2, dv);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_write_read();
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, 32'h10, 32'h9876DCBA);
      n_cmp++; if (busy_o !== (c < 2)) begin n_fail++; $display("FAIL wr_busy cyc%0d: got %b want %b", c, busy_o, (c < 2)); end
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 32'h10, 32'h0);
      n_cmp++; if (busy_o !== (c < 2)) begin n_fail++; $display("FAIL rd_busy cyc%0d: got %b want %b", c, busy_o, (c < 2)); end
      n_cmp++;
      if (ramload !== ((c == 2) ? 32'h9876DCBA : 32'h0)) begin
        n_fail++; $display("FAIL rd_load cyc%0d: got %h want %h", c, ramload, (c == 2) ? 32'h9876DCBA : 32'h0);
      end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (busy_o !== 1'b0 || ramload !== 32'h0) begin n_fail++; $display("FAIL rd_idle: got %b/%h want 0/0", busy_o, ramload); end
  endtask

  task automatic test_alias();
    logic [31:0] rd_addr [2] = '{32'h0000_0234, 32'h0000_0237};
    repeat (3) step(1'b0, 1'b1, 32'hABCD1234, 32'h99991111);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      for (int c = 0; c < 3; c++) begin
        step(1'b1, 1'b0, rd_addr[k], 32'h0);
        if (c == 2) begin
          n_cmp++; if (ramload !== 32'h99991111) begin n_fail++; $display("FAIL alias_load addr %h: got %h want 99991111", rd_addr[k], ramload); end
        end
      end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_restart();
    repeat (3) step(1'b0, 1'b1, 32'h20, 32'h20202020);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h10, 32'h0);
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL restart_busy cyc0: got %b want 1", busy_o); end
    for (int c = 1; c < 4; c++) begin
      step(1'b1, 1'b0, 32'h20, 32'h0);
      n_cmp++; if (busy_o !== (c < 3)) begin n_fail++; $display("FAIL restart_busy cyc%0d: got %b want %b", c, busy_o, (c < 3)); end
      n_cmp++;
      if (ramload !== ((c == 3) ? 32'h20202020 : 32'h0)) begin
        n_fail++; $display("FAIL restart_load cyc%0d: got %h want %h", c, ramload, (c == 3) ? 32'h20202020 : 32'h0);
      end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_read_40(input string tag);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 32'h40, 32'h0);
      if (c == 2) begin
        n_cmp++; if (ramload !== 32'h11114040) begin n_fail++; $display("FAIL %s: got %h want 11114040", tag, ramload); end
      end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_abort();
    repeat (3) step(1'b0, 1'b1, 32'h40, 32'h11114040);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_busy cyc0: got %b want 1", busy_o); end
    step(1'b0, 1'b0, 32'h40, 32'hDEADBEEF);
    n_cmp++; if (busy_o !== 1'b0 || ramload !== 32'h0) begin n_fail++; $display("FAIL abort_drop: got %b/%h want 0/0", busy_o, ramload); end
    check_read_40("abort_no_commit");
  endtask

  task automatic test_reset_abort();
    step(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rstab_busy cyc0: got %b want 1", busy_o); end
    assert_reset();
    #1;
    n_cmp++; if (busy_o !== 1'b0 || ramload !== 32'h0) begin n_fail++; $display("FAIL rstab_outputs: got %b/%h want 0/0", busy_o, ramload); end
    step(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    n_cmp++; if (busy_o !== 1'b0 || busy0 !== 1'b0 || ramload0 !== 32'h0) begin n_fail++; $display("FAIL rstab_held: got %b/%b/%h want 0/0/0", busy_o, busy0, ramload0); end
    Wen = 1'b0;
    release_reset();
    check_read_40("rstab_no_commit");
  endtask

  task automatic test_lat0();
    step(1'b1, 1'b0, 32'h10, 32'h0);
    n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL lat0_busy: got %b want 0", busy0); end
    n_cmp++; if (ramload0 !== 32'h9876DCBA) begin n_fail++; $display("FAIL lat0_load: got %h want 9876dcba", ramload0); end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, 32'h54, 32'h5454ABAB);
      n_cmp++; if (busy0 !== 1'b0 || ramload0 !== 32'h0) begin n_fail++; $display("FAIL lat0_rw cyc%0d: got %b/%h want 0/0", c, busy0, ramload0); end
      n_cmp++; if (busy_o !== (c < 2)) begin n_fail++; $display("FAIL rw_busy cyc%0d: got %b want %b", c, busy_o, (c < 2)); end
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 32'h54, 32'h0);
      n_cmp++; if (ramload0 !== 32'h5454ABAB) begin n_fail++; $display("FAIL lat0_rw_read cyc%0d: got %h want 5454abab", c, ramload0); end
      if (c == 2) begin
        n_cmp++; if (ramload !== 32'h5454ABAB) begin n_fail++; $display("FAIL rw_read: got %h want 5454abab", ramload); end
      end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic        r, w;
    logic [9:0]  wd;
    logic [31:0] d, a, v;
    int          kind, hold;
    repeat (150) begin
      if ($urandom_range(0, 29) == 0) begin
        assert_reset();
        step(1'b0, 1'b0, 32'h0, 32'h0);
        release_reset();
      end
      kind = $urandom_range(0, 9);
      r = (kind < 5) || (kind == 9);
      w = (kind >= 5) && (kind != 8);
      if (kind == 8) r = 1'b0;
      wd   = 10'($urandom_range(0, 7) * 37);
      d    = $urandom;
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        a = ($urandom & 32'hFFFF_F003) | (32'(wd) << 2);
        step(r, w, a, d);
        n_cmp++; if (busy_o !== exp_busy[0]) begin n_fail++; $display("FAIL rnd_busy2: got %b want %b", busy_o, exp_busy[0]); end
        n_cmp++; if (ramload !== exp_load[0]) begin n_fail++; $display("FAIL rnd_load2: got %h want %h", ramload, exp_load[0]); end
        n_cmp++; if (busy0 !== exp_busy[1]) begin n_fail++; $display("FAIL rnd_busy0: got %b want %b", busy0, exp_busy[1]); end
        n_cmp++; if (ramload0 !== exp_load[1]) begin n_fail++; $display("FAIL rnd_load0: got %h want %h", ramload0, exp_load[1]); end
        if (exp_cpl[0] && r && !w) exp_q.push_back(exp_load[0]);
        if (busy_o === 1'b0 && Ren && !Wen) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL sb_unexpected: got completion %h, required none", ramload);
          end else begin
            v = exp_q.pop_front();
            if (ramload !== v) begin n_fail++; $display("FAIL sb_read: got %h want %h", ramload, v); end
          end
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size()); end
    step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_alias();
    test_restart();
    test_abort();
    test_reset_abort();
    test_lat0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
